bioee_clkdiv_multi: RTL and testbench

Parametrised multi-channel integer clock divider. It generates NCH independent divided clocks/enables from clkin. Each channel supports any divisor ≥2, including odd values. Divisor changes are glitch-free and take effect at the period boundary; a common sync pulse re-phases all running channels. Outputs are registered levels in the clkin domain, used as slow sample/strobe clocks for the readout and stimulus blocks.

---
 rtl/bioee_clkdiv_multi.sv | 156 +++++++++++++++
 tb/tb_bioee_clkdiv_multi.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/bioee_clkdiv_multi.sv
// Multi-channel integer clock divider: NCH independent divided clocks from clkin,
// with shadowed divisor loads applied at period boundaries and a common re-phase strobe.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | output low, counter held at 0, pending divisor applied here
// ST_RUN  | dividing; restarts each period while enable stays high
// ST_STOP | enable dropped; finishes the current period, then goes idle
module bioee_clkdiv_multi #(
    parameter int NCH         = 4,
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                 clkin,
    input  logic                 resetn,
    input  logic [NCH-1:0]       enable,
    input  logic [NCH-1:0]       load,
    input  logic [NCH*WIDTH-1:0] div_in,
    input  logic                 sync,
    output logic [NCH-1:0]       clkout,
    output logic [NCH-1:0]       tick,
    output logic [NCH-1:0]       running,
    output logic [NCH-1:0]       pending
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] DIV_MIN = WIDTH'(2);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        state_t           state_q, state_d;
        logic [WIDTH-1:0] cnt_q, cnt_d;
        logic [WIDTH-1:0] div_act_q, div_act_d;
        logic [WIDTH-1:0] div_sh_q, div_sh_d;
        logic             pend_q, pend_d;
        logic             clk_q, clk_d;
        logic             tick_q, tick_d;
        logic             apply;

        logic [WIDTH-1:0] slice;
        logic [WIDTH-1:0] cnt_inc;
        logic [WIDTH:0]   hi_len;
        logic [WIDTH-1:0] div_next;
        logic             div_ok;
        logic             boundary;

        assign slice    = div_in[c*WIDTH +: WIDTH];
        assign cnt_inc  = cnt_q + 1'b1;
        assign hi_len   = ({1'b0, div_act_q} + 1'b1) >> 1;
        // Divisor the next period would use if it started now.
        assign div_next = pend_q ? div_sh_q : div_act_q;
        assign div_ok   = (div_next >= DIV_MIN);
        assign boundary = (state_q != ST_IDLE) && (cnt_q == div_act_q - 1'b1);

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            clk_d     = clk_q;
            tick_d    = 1'b0;
            div_act_d = div_act_q;
            apply     = 1'b0;

            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    clk_d = 1'b0;
                    if (pend_q) begin
                        div_act_d = div_sh_q;
                        apply     = 1'b1;
                    end else if (enable[c] && (div_act_q >= DIV_MIN)) begin
                        state_d = ST_RUN;
                        clk_d   = 1'b1;
                        tick_d  = 1'b1;
                    end
                end
                ST_RUN, ST_STOP: begin
                    if (sync) begin
                        div_act_d = div_next;
                        apply     = pend_q;
                        cnt_d     = '0;
                        if ((state_q == ST_STOP) || !div_ok) begin
                            state_d = ST_IDLE;
                            clk_d   = 1'b0;
                        end else begin
                            state_d = enable[c] ? ST_RUN : ST_STOP;
                            clk_d   = 1'b1;
                            tick_d  = 1'b1;
                        end
                    end else if (boundary) begin
                        cnt_d = '0;
                        if ((state_q == ST_RUN) || enable[c]) begin
                            div_act_d = div_next;
                            apply     = pend_q;
                            if (!div_ok) begin
                                state_d = ST_IDLE;
                                clk_d   = 1'b0;
                            end else begin
                                state_d = enable[c] ? ST_RUN : ST_STOP;
                                clk_d   = 1'b1;
                                tick_d  = 1'b1;
                            end
                        end else begin
                            // Stopped channel ends its last full period; no truncated pulse.
                            state_d = ST_IDLE;
                            clk_d   = 1'b0;
                        end
                    end else begin
                        cnt_d   = cnt_inc;
                        clk_d   = ({1'b0, cnt_inc} < hi_len);
                        state_d = enable[c] ? ST_RUN : ST_STOP;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    clk_d   = 1'b0;
                end
            endcase
        end

        // A load in the same cycle as an apply stays pending for the next one.
        assign div_sh_d = load[c] ? slice : div_sh_q;
        assign pend_d   = load[c] ? 1'b1 : (apply ? 1'b0 : pend_q);

        always_ff @(posedge clkin or negedge resetn) begin
            if (!resetn) begin
                state_q   <= ST_IDLE;
                cnt_q     <= '0;
                div_act_q <= DIV_RST;
                div_sh_q  <= DIV_RST;
                pend_q    <= 1'b0;
                clk_q     <= 1'b0;
                tick_q    <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                div_act_q <= div_act_d;
                div_sh_q  <= div_sh_d;
                pend_q    <= pend_d;
                clk_q     <= clk_d;
                tick_q    <= tick_d;
            end
        end

        assign clkout[c]  = clk_q;
        assign tick[c]    = tick_q;
        assign running[c] = (state_q != ST_IDLE);
        assign pending[c] = pend_q;
    end

endmodule

// File: tb/tb_bioee_clkdiv_multi.sv
// Directed bench for bioee_clkdiv_multi: hand-computed clkout/tick patterns per scenario.
module tb_bioee_clkdiv_multi;

    localparam int NCH   = 4;
    localparam int WIDTH = 16;

    logic                 clkin = 1'b0;
    logic                 resetn;
    logic [NCH-1:0]       enable;
    logic [NCH-1:0]       load;
    logic [NCH*WIDTH-1:0] div_in;
    logic                 sync;
    logic [NCH-1:0]       clkout;
    logic [NCH-1:0]       tick;
    logic [NCH-1:0]       running;
    logic [NCH-1:0]       pending;

    int n_chk = 0;
    int n_err = 0;

    bioee_clkdiv_multi #(
        .NCH        (NCH),
        .WIDTH      (WIDTH),
        .DEFAULT_DIV(2)
    ) dut (
        .clkin  (clkin),
        .resetn (resetn),
        .enable (enable),
        .load   (load),
        .div_in (div_in),
        .sync   (sync),
        .clkout (clkout),
        .tick   (tick),
        .running(running),
        .pending(pending)
    );

    always #5 clkin = ~clkin;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clkin);
        #1;
    endtask

    task automatic set_div(input int ch, input logic [WIDTH-1:0] val);
        div_in[ch*WIDTH +: WIDTH] = val;
        load[ch] = 1'b1;
    endtask

    // One step per pattern character; '1' means high after that edge.
    task automatic run_seq(input string tag, input int ch, input string clk_pat, input string tick_pat);
        byte b;
        for (int i = 0; i < clk_pat.len(); i++) begin
            step();
            b = clk_pat[i];
            chk($sformatf("%s clk[%0d]", tag, i), 32'(clkout[ch]), 32'(b == "1"));
            b = tick_pat[i];
            chk($sformatf("%s tick[%0d]", tag, i), 32'(tick[ch]), 32'(b == "1"));
        end
    endtask

    logic [1:0] exp_clk [4] = '{2'b11, 2'b10, 2'b00, 2'b01};
    logic [1:0] exp_tck [4] = '{2'b00, 2'b00, 2'b00, 2'b01};

    initial begin
        resetn = 1'b0;
        enable = '0;
        load   = '0;
        div_in = '0;
        sync   = 1'b0;
        step();
        step();
        chk("rst clkout", 32'(clkout), 32'h0);
        chk("rst tick", 32'(tick), 32'h0);
        chk("rst running", 32'(running), 32'h0);
        chk("rst pending", 32'(pending), 32'h0);
        resetn = 1'b1;
        step();

        // Default divisor 2, then enable dropped on a boundary cycle
        enable[3] = 1'b1;
        run_seq("def2", 3, "1010", "1010");
        enable[3] = 1'b0;
        run_seq("def2_stop", 3, "100", "100");
        chk("def2 running", 32'(running[3]), 32'h0);

        // div=4
        set_div(0, 16'd4);
        step();
        load = '0;
        chk("d4 pend set", 32'(pending[0]), 32'h1);
        step();
        chk("d4 pend idle apply", 32'(pending[0]), 32'h0);
        enable[0] = 1'b1;
        run_seq("d4", 0, "11001100", "10001000");
        chk("d4 running", 32'(running[0]), 32'h1);

        // Load 6 at cnt=1: current period finishes, then 3H/3L
        run_seq("d4b", 0, "11", "10");
        set_div(0, 16'd6);
        step();
        load = '0;
        chk("ld6 clk", 32'(clkout[0]), 32'h0);
        chk("ld6 pend", 32'(pending[0]), 32'h1);
        run_seq("d4c", 0, "0", "0");
        chk("ld6 pend hold", 32'(pending[0]), 32'h1);
        run_seq("d6", 0, "111000111000", "100000100000");
        chk("d6 pend clr", 32'(pending[0]), 32'h0);

        // Disable at cnt=1 of div=6
        run_seq("d6b", 0, "11", "10");
        enable[0] = 1'b0;
        run_seq("stop6a", 0, "1000", "0000");
        chk("stop6 running mid", 32'(running[0]), 32'h1);
        run_seq("stop6b", 0, "000", "000");
        chk("stop6 running end", 32'(running[0]), 32'h0);

        // Sync: ch0 div=4, ch1 div=6 out of phase, ch2 idle
        set_div(0, 16'd4);
        set_div(1, 16'd6);
        step();
        load = '0;
        step();
        enable[0] = 1'b1;
        step();
        enable[1] = 1'b1;
        step();
        step();
        chk("presync clk", 32'(clkout[1:0]), 32'h2);
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk("sync clk", 32'(clkout[1:0]), 32'h3);
        chk("sync tick", 32'(tick[1:0]), 32'h3);
        chk("sync idle clk", 32'(clkout[2]), 32'h0);
        chk("sync idle tick", 32'(tick[2]), 32'h0);
        chk("sync idle running", 32'(running[2]), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("postsync clk[%0d]", i), 32'(clkout[1:0]), 32'(exp_clk[i]));
            chk($sformatf("postsync tick[%0d]", i), 32'(tick[1:0]), 32'(exp_tck[i]));
        end

        // Sync while ch1 is in STOP sends it idle
        enable[1] = 1'b0;
        step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk("syncstop running1", 32'(running[1]), 32'h0);
        chk("syncstop clk1", 32'(clkout[1]), 32'h0);
        chk("syncstop tick1", 32'(tick[1]), 32'h0);
        chk("syncstop tick0", 32'(tick[0]), 32'h1);

        // Load div=1 while running div=4: clean stop at boundary
        set_div(0, 16'd1);
        step();
        load = '0;
        chk("ld1 clk", 32'(clkout[0]), 32'h1);
        chk("ld1 pend", 32'(pending[0]), 32'h1);
        run_seq("ld1", 0, "0000", "0000");
        chk("ld1 running", 32'(running[0]), 32'h0);
        chk("ld1 pend clr", 32'(pending[0]), 32'h0);

        // Load 5 then enable: one idle cycle to apply, then 3H/2L
        set_div(1, 16'd5);
        step();
        load = '0;
        chk("d5 pend", 32'(pending[1]), 32'h1);
        enable[1] = 1'b1;
        step();
        chk("d5 pend clr", 32'(pending[1]), 32'h0);
        chk("d5 idle", 32'(running[1]), 32'h0);
        run_seq("d5", 1, "11100111", "10000100");

        // Async reset during the high phase
        #2;
        resetn = 1'b0;
        #1;
        chk("arst clkout", 32'(clkout), 32'h0);
        chk("arst running", 32'(running), 32'h0);
        chk("arst pending", 32'(pending), 32'h0);
        step();
        resetn = 1'b1;
        run_seq("post_rst", 1, "1010", "1010");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
